// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: widths, reset PC default,
// NOP encoding and the buffered {pc, instr} entry type.
package fetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // Sequential word fetch; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] next_fetch_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Circular buffer of {pc, instr} entries with read/write pointers and occupancy count.
// Clear has priority over push and pop; DEPTH must be a power of two so pointers wrap naturally.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fq_entry_t        wdata,
    output fq_entry_t        rdata,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !clear && (count_q != FULL_CNT);
        do_pop   = pop && !clear && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload is never reset; consumers gate it with count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID: one outstanding sequential fetch, redirect flush
// with in-flight response drop. Optional performance counters under `define FQ_PERF_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef FQ_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              push, pop, clear, rsp;
    logic [CNT_W-1:0]  count;
    fq_entry_t         head, wentry;

    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (wentry),
        .rdata (head),
        .count (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;

    always_comb begin
        busy_d       = busy_q;
        drop_d       = drop_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        imem_addr_d  = imem_addr_q;
        imem_req_d   = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        clear        = 1'b0;
        wentry.pc    = req_pc_q;
        wentry.instr = imem_rdata;
        rsp          = busy_q && imem_rvalid;

        if (rsp) busy_d = 1'b0;

        if (redirect_valid) begin
            clear      = 1'b1;
            fetch_pc_d = redirect_pc;
            drop_d     = busy_q && !imem_rvalid;
        end else begin
            if (rsp) begin
                if (drop_q) drop_d = 1'b0;
                else        push   = 1'b1;
            end
            pop = out_valid && out_ready;
            // Issue only with no fetch in flight, so a free slot is always reserved for its response.
            if (!busy_q && (count != FULL_CNT)) begin
                imem_req_d  = 1'b1;
                imem_addr_d = fetch_pc_q;
                req_pc_d    = fetch_pc_q;
                busy_d      = 1'b1;
                fetch_pc_d  = next_fetch_pc(fetch_pc_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            imem_addr_q <= RESET_PC;
        end else begin
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            imem_req_q  <= imem_req_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

`ifdef FQ_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q + ((out_valid && !out_ready) ? 32'd1 : 32'd0);
        perf_flush_cnt_d = perf_flush_cnt_q + (redirect_valid ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, scored against an
// in-order PC-stream model with a variable-latency instruction memory responder.
module tb_fetch_queue;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FQ_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_queue #(.DEPTH(4), .RESET_PC(TB_RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FQ_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          pops = 0;
    int          rsp_seen = 0;
    int          pend = 0;
    int          mem_lat = 1;
    int          stall_exp = 0;
    int          flush_exp = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_pc = TB_RESET_PC;
    logic        last_redir = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scores the edge about to happen, advances one cycle, then runs the memory responder.
    task automatic tick();
        if (!reset) begin
            if (out_valid && !out_ready) stall_exp++;
            if (redirect_valid) begin
                flush_exp++;
                exp_pc = redirect_pc;
            end else if (out_valid && out_ready) begin
                check("pop_pc", out_pc, exp_pc);
                check("pop_instr", out_instr, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        last_redir = redirect_valid && !reset;
        @(posedge clk);
        @(negedge clk);
        if (last_redir) check("empty_after_redirect", 32'(out_valid), 32'd0);
        imem_rvalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend_addr);
                rsp_seen++;
            end
        end
        if (imem_req) begin
            pend      = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
            pend_addr = imem_addr;
        end
    endtask

    initial begin
        int p0;
        int req_late;
        logic found;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, TB_RESET_PC);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);

        // 1: sequential fetch, 1-cycle memory, always ready
        mem_lat = 1;
        out_ready = 1'b1;
        reset = 1'b0;
        tick();
        check("t1_first_req", 32'(imem_req), 32'd1);
        check("t1_first_addr", imem_addr, TB_RESET_PC);
        tick();
        check("t1_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid_latency", 32'(out_valid), 32'd1);
        check("t1_head_pc", out_pc, 32'h0);
        repeat (10) tick();
        check("t1_pops_ge3", 32'(pops >= 3), 32'd1);

        // 2: stall until full, then drain
        out_ready = 1'b0;
        req_late = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i >= 14 && imem_req) req_late++;
        end
        check("t2_no_req_when_full", req_late, 0);
        check("t2_head_valid", 32'(out_valid), 32'd1);
        check("t2_head_pc", out_pc, exp_pc);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_valid", 32'(out_valid), 32'd1);
            tick();
        end

        // 3: redirect while a fetch is outstanding; its response comes 3 cycles later
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_req) found = 1'b1;
            else tick();
        end
        check("t3_wait_req", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check("t3_req_idle", 32'(imem_req), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_req) found = 1'b1;
            else tick();
        end
        check("t3_wait_target_req", 32'(found), 32'd1);
        check("t3_target_addr", imem_addr, 32'h0000_0040);
        p0 = pops;
        repeat (20) tick();
        check("t3_target_popped", 32'(pops >= p0 + 2), 32'd1);

        // 4: redirect coinciding with a response and a pop
        mem_lat = 1;
        out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_rvalid && out_valid) found = 1'b1;
            else tick();
        end
        check("t4_wait_rsp_and_valid", 32'(found), 32'd1);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check("t4_no_req_yet", 32'(imem_req), 32'd0);
        tick();
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_req_addr", imem_addr, 32'h0000_0100);

        // 5: async reset with two entries queued and a fetch in flight
        mem_lat = 2;
        out_ready = 1'b0;
        rsp_seen = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (rsp_seen >= 2 && imem_req) found = 1'b1;
            else tick();
        end
        check("t5_wait_two_queued", 32'(found), 32'd1);
        check("t5_head_pc", out_pc, 32'h0000_0100);
        #2 reset = 1'b1;
        stall_exp = 0;
        flush_exp = 0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_req", 32'(imem_req), 32'd0);
        check("t5_async_addr", imem_addr, TB_RESET_PC);
        repeat (3) tick();
        check("t5_late_rsp_ignored", 32'(out_valid), 32'd0);
        reset = 1'b0;
        pend = 0;
        imem_rvalid = 1'b0;
        exp_pc = TB_RESET_PC;
        out_ready = 1'b1;
        tick();
        check("t5_req_after_release", 32'(imem_req), 32'd1);
        check("t5_addr_after_release", imem_addr, TB_RESET_PC);

        // PC wrap across 2^32
        mem_lat = 0;
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        p0 = pops;
        repeat (40) tick();
        check("wrap_pops", 32'(pops >= p0 + 3), 32'd1);
        check("wrap_low_pc", 32'(exp_pc < 32'h0000_0100), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(9, 0) < 7);
            if ($urandom_range(31, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom() & 32'hFFFF_FFFC;
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) tick();
        check("rand_pops_progress", 32'(pops > 100), 32'd1);

`ifdef FQ_PERF_EN
        check("perf_stall_model", perf_stall_cnt, 32'(stall_exp));
        check("perf_flush_model", perf_flush_cnt, 32'(flush_exp));

        // 6: 7 stall cycles and 2 redirects from a fresh reset
        reset = 1'b1;
        pend = 0;
        imem_rvalid = 1'b0;
        tick();
        tick();
        stall_exp = 0;
        flush_exp = 0;
        exp_pc = TB_RESET_PC;
        mem_lat = 1;
        out_ready = 1'b0;
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else tick();
        end
        check("t6_wait_valid", 32'(found), 32'd1);
        repeat (7) tick();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("t6_stall_cnt", perf_stall_cnt, 32'd7);
        check("t6_flush_cnt", perf_flush_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
